dds_sine_source: RTL and testbench

Phase-accumulator sine generator that produces the 16-bit test tone feeding the FIR stage's AXI4-Stream slave input (`s_axis_data_*`). It sits directly upstream of the FIR experiment block in the NMR receive-path simulation and bring-up chain. It replaces a free-running sine source with one that honours `tready` back-pressure, so the stream the FIR sees is phase-continuous regardless of stalls. The tuning word is supplied by the host already converted from Hz: `phase_inc = frq_hz * 2^32 / 200e6`.

---
 rtl/dds_sine_source_pkg.sv | 28 ++
 rtl/dds_sine_source_if.sv | 23 ++
 rtl/dds_sine_source_rom.sv | 38 +++
 rtl/dds_sine_source.sv | 164 ++++++++++++++++
 tb/tb_dds_sine_source.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_sine_source_pkg.sv
// Shared widths, constants, types and the quarter-wave table generator for the DDS sine source.
// Latency: none; elaboration-time definitions only.
// Backpressure: not applicable; no datapath or handshake lives here.
package nmr_dds_pkg;

  localparam int  PHASE_W   = 32;
  localparam int  LUT_AW    = 10;
  localparam int  DATA_W    = 16;
  localparam int  MAG_W     = DATA_W - 1;
  localparam int  LUT_DEPTH = 1 << LUT_AW;
  localparam int  AMP       = 32767;
  localparam int  FCLK_HZ   = 200_000_000;
  localparam real PI        = 3.14159265358979323846;

  typedef logic [1:0]        quadrant_t;
  typedef logic [LUT_AW-1:0] lut_addr_t;
  typedef logic [MAG_W-1:0]  mag_t;

  // Entry k of the first quadrant, sampled at the centre of its phase bin.
  // The half-bin offset makes ~k the exact mirror of k, so odd quadrants
  // reuse the table unchanged.
  function automatic mag_t quarter_sine(input int k);
    real ang;
    ang = (real'(k) + 0.5) * 2.0 * PI / real'(4 * LUT_DEPTH);
    return mag_t'(int'(real'(AMP) * $sin(ang)));
  endfunction

endpackage

// File: rtl/dds_sine_source_if.sv
// AXI4-Stream style sample bus between the DDS source and its consumer.
// Latency: none; wires only.
// Backpressure: tready from the slave stalls the master while tvalid is held.
interface dds_sine_source_if;
  import nmr_dds_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/dds_sine_source_rom.sv
// Quarter-wave sine magnitude ROM, 1024 x 15, contents built at elaboration.
// Latency: 1 cycle registered read.
// Backpressure: rd_en low freezes the output register so a stalled pipeline keeps its value.
module sine_quarter_rom
  import nmr_dds_pkg::*;
(
  input  logic      clk,
  input  lut_addr_t addr,
  input  logic      rd_en,
  output mag_t      mag
);

  wire [MAG_W-1:0] rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam mag_t MAG = quarter_sine(k);
    assign rom[k] = MAG;
  end

  mag_t mag_q;
  mag_t mag_d;

  // Read a new entry only when the pipeline advances.
  always_comb begin
    mag_d = mag_q;
    if (rd_en) begin
      mag_d = rom[addr];
    end
  end

  // Output register; no reset so it can map onto block RAM output flops.
  always_ff @(posedge clk) begin
    mag_q <= mag_d;
  end

  assign mag = mag_q;

endmodule

// File: rtl/dds_sine_source.sv
// Phase-accumulator sine source feeding an AXI4-Stream consumer, phase-continuous across stalls.
// Latency: 4 advancing cycles from accumulator issue to tvalid; 1 sample per clock when unstalled.
// Backpressure: tvalid && !tready freezes every stage and the accumulator; nothing dropped or duplicated.
module dds_sine_source
  import nmr_dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  dds_sine_source_if.master  m_axis_data
);

  // Only the quadrant and table index bits of the phase travel down the pipe.
  localparam int TOP_W = 2 + LUT_AW;

  logic               ce;

  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] acc_d;
  logic [TOP_W-1:0]   s1_phase_q;
  logic [TOP_W-1:0]   s1_phase_d;
  logic               s1_vld_q;
  logic               s1_vld_d;

  lut_addr_t          s2_addr_q;
  lut_addr_t          s2_addr_d;
  quadrant_t          s2_quad_q;
  quadrant_t          s2_quad_d;
  logic               s2_vld_q;
  logic               s2_vld_d;

  mag_t               s3_mag;
  quadrant_t          s3_quad_q;
  quadrant_t          s3_quad_d;
  logic               s3_vld_q;
  logic               s3_vld_d;

  logic [DATA_W-1:0]  mag_ext;
  logic [DATA_W-1:0]  out_dat_q;
  logic [DATA_W-1:0]  out_dat_d;
  logic               out_vld_q;
  logic               out_vld_d;

  // Whole pipeline moves together; only a held output beat stops it.
  assign ce = !(out_vld_q && !m_axis_data.tready);

  // S1: issue the current phase as a new sample and step the accumulator.
  always_comb begin
    acc_d      = acc_q;
    s1_phase_d = s1_phase_q;
    s1_vld_d   = s1_vld_q;
    if (ce) begin
      s1_vld_d = enable;
      if (enable) begin
        s1_phase_d = acc_q[PHASE_W-1 -: TOP_W];
        acc_d      = acc_q + phase_inc;
      end
    end
  end

  // S1 registers; reset restarts the tone at phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      s1_phase_q <= '0;
      s1_vld_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      s1_phase_q <= s1_phase_d;
      s1_vld_q   <= s1_vld_d;
    end
  end

  // S2: split quadrant from index; odd quadrants walk the table backwards.
  always_comb begin
    s2_addr_d = s2_addr_q;
    s2_quad_d = s2_quad_q;
    s2_vld_d  = s2_vld_q;
    if (ce) begin
      s2_quad_d = quadrant_t'(s1_phase_q[TOP_W-1 -: 2]);
      s2_addr_d = s1_phase_q[LUT_AW-1:0] ^ {LUT_AW{s1_phase_q[LUT_AW]}};
      s2_vld_d  = s1_vld_q;
    end
  end

  // S2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_addr_q <= '0;
      s2_quad_q <= '0;
      s2_vld_q  <= 1'b0;
    end else begin
      s2_addr_q <= s2_addr_d;
      s2_quad_q <= s2_quad_d;
      s2_vld_q  <= s2_vld_d;
    end
  end

  sine_quarter_rom u_rom (
    .clk   (clk),
    .addr  (s2_addr_q),
    .rd_en (ce),
    .mag   (s3_mag)
  );

  // S3: carry the quadrant and valid alongside the ROM read.
  always_comb begin
    s3_quad_d = s3_quad_q;
    s3_vld_d  = s3_vld_q;
    if (ce) begin
      s3_quad_d = s2_quad_q;
      s3_vld_d  = s2_vld_q;
    end
  end

  // S3 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_quad_q <= '0;
      s3_vld_q  <= 1'b0;
    end else begin
      s3_quad_q <= s3_quad_d;
      s3_vld_q  <= s3_vld_d;
    end
  end

  assign mag_ext = {1'b0, s3_mag};

  // S4: apply sign for the lower half-cycle; data is left untouched on bubbles.
  always_comb begin
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    if (ce) begin
      out_vld_d = s3_vld_q;
      if (s3_vld_q) begin
        out_dat_d = s3_quad_q[1] ? (DATA_W'(0) - mag_ext) : mag_ext;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign m_axis_data.tdata  = out_dat_q;
  assign m_axis_data.tvalid = out_vld_q;

  // A stalled beat must be presented again unchanged.
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (out_vld_q && !m_axis_data.tready) |=> (out_vld_q && $stable(out_dat_q)));

  // The magnitude never exceeds AMP, so the most negative code cannot appear.
  a_no_min_code : assert property (@(posedge clk) disable iff (rst)
    out_vld_q |-> (out_dat_q != {1'b1, {(DATA_W-1){1'b0}}}));

endmodule

// File: tb/tb_dds_sine_source.sv
// Self-checking bench for dds_sine_source: directed runs against a full-circle sine model.
// Latency: checks the 4-edge first-sample timing and per-sample values on every accepted beat.
// Backpressure: drives steady and random tready, checks held data during stalls.
module tb_dds_sine_source;
  import nmr_dds_pkg::*;

  localparam logic [31:0] INC_QUARTER = 32'h4000_0000;
  localparam logic [31:0] INC_5MHZ    = 32'd107374182;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        enable    = 1'b0;
  logic [31:0] phase_inc = '0;

  dds_sine_source_if axis_if ();

  dds_sine_source dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .phase_inc   (phase_inc),
    .m_axis_data (axis_if)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          accept_cnt  = 0;
  int          stall_cnt   = 0;
  logic [31:0] model_phase = '0;
  logic [31:0] model_inc   = '0;
  bit          rdy_level   = 1'b1;
  bit          rand_rdy    = 1'b0;
  int          got_q[$];
  int          ref_seq[$];
  int          quarter_pat[4] = '{25, 32767, -25, -32767};

  // Full-circle model: 4096 bins per cycle, each sampled at its centre.
  function automatic int model_sample(input logic [31:0] ph);
    int  m;
    real ang;
    m   = int'(ph[31:20]);
    ang = (real'(m) + 0.5) * 2.0 * 3.14159265358979323846 / 4096.0;
    return int'(32767.0 * $sin(ang));
  endfunction

  function automatic int q_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'h7fff_ffff;
  endfunction

  function automatic int ref_at(input int i);
    return (i < ref_seq.size()) ? ref_seq[i] : 32'h7fff_fffe;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_accepts(input int n, input int budget, input string name);
    int target;
    target = accept_cnt + n;
    while (accept_cnt < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    vectors++;
    if (accept_cnt < target) begin
      miscompares++;
      $display("FAIL %s: only %0d of %0d samples arrived within budget", name,
               n - (target - accept_cnt), n);
    end
  endtask

  task automatic start_run(input logic [31:0] inc);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    enable      = 1'b0;
    phase_inc   = inc;
    model_inc   = inc;
    model_phase = '0;
    rdy_level   = 1'b1;
    rand_rdy    = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    got_q.delete();
  endtask

  // tready driver: steady level or a coin flip every cycle.
  initial begin
    axis_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      axis_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Compare process: every accepted beat against the model, every stall for held data.
  initial begin : compare
    bit stall_prev;
    int stall_dat;
    int got;
    stall_prev = 1'b0;
    stall_dat  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        got = int'($signed(axis_if.tdata));
        if (stall_prev) begin
          check("stall_tvalid", int'(axis_if.tvalid), 1);
          check("stall_tdata", got, stall_dat);
        end
        if (axis_if.tvalid && axis_if.tready) begin
          check("sample", got, model_sample(model_phase));
          model_phase = model_phase + model_inc;
          got_q.push_back(got);
          accept_cnt++;
        end
        stall_prev = axis_if.tvalid && !axis_if.tready;
        if (stall_prev) stall_cnt++;
        stall_dat = got;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rise;
    int mx;
    int mn;
    int sum;
    int drained;

    // Reset state and first-sample timing with a DC tone.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tvalid", int'(axis_if.tvalid), 0);
    check("reset_tdata", int'($signed(axis_if.tdata)), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    rise   = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (axis_if.tvalid && rise == 0) rise = e;
    end
    check("tvalid_rise_edge", rise, 4);
    wait_accepts(6, 50, "dc_run");
    check("dc_value", q_at(got_q.size() - 1), 25);

    // Quarter-cycle step: the four quadrant centres in turn.
    start_run(INC_QUARTER);
    wait_accepts(12, 60, "quarter_run");
    for (int i = 0; i < 12; i++) check("quarter_seq", q_at(i), quarter_pat[i % 4]);

    // 5 MHz reference run with tready held high.
    start_run(INC_5MHZ);
    wait_accepts(80, 200, "ref_run");
    ref_seq = got_q;
    mx  = -100000;
    mn  = 100000;
    sum = 0;
    for (int i = 0; i < 40; i++) begin
      if (q_at(i) > mx) mx = q_at(i);
      if (q_at(i) < mn) mn = q_at(i);
      sum += q_at(i);
    end
    check("peak_5mhz", mx, 32767);
    check("trough_5mhz", mn, -32767);
    check("mean_5mhz", (sum > -2400 && sum < 2400) ? 1 : 0, 1);

    // Same tone under random backpressure must give the same accepted sequence.
    start_run(INC_5MHZ);
    stall_cnt = 0;
    rand_rdy  = 1'b1;
    wait_accepts(80, 1500, "bp_run");
    rand_rdy = 1'b0;
    for (int i = 0; i < 80; i++) check("bp_seq", q_at(i), ref_at(i));
    check("bp_stalls_seen", (stall_cnt > 0) ? 1 : 0, 1);

    // Enable gap: the three samples behind the output drain, then the stream resumes seamlessly.
    wait_accepts(5, 50, "pre_gap");
    @(posedge clk);
    #1;
    enable  = 1'b0;
    drained = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (axis_if.tvalid && axis_if.tready) drained++;
    end
    check("gap_drained", drained, 3);
    check("gap_tvalid", int'(axis_if.tvalid), 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_accepts(20, 80, "post_gap");

    // Reset while stalled: output drops next cycle, tone restarts at phase 0.
    @(posedge clk);
    #1;
    rdy_level = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_before_rst", int'(axis_if.tvalid), 1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    model_phase = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", int'(axis_if.tvalid), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rdy_level = 1'b1;
    got_q.delete();
    wait_accepts(3, 40, "post_rst");
    check("post_rst_first", q_at(0), 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
